// File: rtl/dualport_ram_slave_if.sv
// dualport_bus: request/grant bus between the load/store stage and the data RAM
interface dualport_bus;
    logic        rd_req;
    logic [3:0]  rd_be;
    logic [31:0] rd_addr;
    logic        rd_gnt;
    logic [31:0] rd_data;
    logic        wr_req;
    logic [3:0]  wr_be;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_gnt;
    modport master (
        output rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
        input  rd_gnt, rd_data, wr_gnt
    );
    modport slave (
        input  rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
        output rd_gnt, rd_data, wr_gnt
    );
endinterface

// File: rtl/dualport_ram_slave.sv
// dualport_ram_slave: word-addressed RAM slave with per-port wait states and byte-enabled writes
module dualport_ram_slave #(
    parameter int unsigned DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned RD_WAIT   = 0,
    parameter int unsigned WR_WAIT   = 0
) (
    input  logic        clk,
    input  logic        rst,
    dualport_bus.slave  mem_slave,
    input  logic        i_err_clr,
    output logic        o_err,
    output logic [31:0] o_rd_cnt,
    output logic [31:0] o_wr_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {R_IDLE, R_WAIT} r_state_t;
    typedef enum logic {W_IDLE, W_WAIT} w_state_t;

    r_state_t      r_state, r_state_d;
    w_state_t      w_state, w_state_d;
    logic [3:0]    rcnt, rcnt_d, wcnt, wcnt_d;
    logic          rd_gnt, wr_gnt;
    logic [31:0]   rd_off, wr_off;
    logic          rd_ok, wr_ok;
    logic [AW-1:0] rd_idx, wr_idx;
    logic [31:0]   mem [DEPTH];
    logic          unused_ok;

    assign rd_off    = mem_slave.rd_addr - BASE_ADDR;
    assign wr_off    = mem_slave.wr_addr - BASE_ADDR;
    assign rd_ok     = (rd_off >> (AW + 2)) == 32'd0;
    assign wr_ok     = (wr_off >> (AW + 2)) == 32'd0;
    assign rd_idx    = rd_off[AW+1:2];
    assign wr_idx    = wr_off[AW+1:2];
    assign unused_ok = ^mem_slave.rd_be;

    always_comb begin
        r_state_d = r_state;
        rcnt_d    = rcnt;
        rd_gnt    = 1'b0;
        if (r_state == R_IDLE) begin
            if (mem_slave.rd_req) begin
                if (RD_WAIT == 0) rd_gnt = 1'b1;
                else begin
                    r_state_d = R_WAIT;
                    rcnt_d    = 4'd1;
                end
            end
        end else if (!mem_slave.rd_req) begin
            r_state_d = R_IDLE;
            rcnt_d    = 4'd0;
        end else if (rcnt == 4'(RD_WAIT)) begin
            rd_gnt    = 1'b1;
            r_state_d = R_IDLE;
            rcnt_d    = 4'd0;
        end else rcnt_d = rcnt + 4'd1;
        if (rst) rd_gnt = 1'b0;
    end

    always_comb begin
        w_state_d = w_state;
        wcnt_d    = wcnt;
        wr_gnt    = 1'b0;
        if (w_state == W_IDLE) begin
            if (mem_slave.wr_req) begin
                if (WR_WAIT == 0) wr_gnt = 1'b1;
                else begin
                    w_state_d = W_WAIT;
                    wcnt_d    = 4'd1;
                end
            end
        end else if (!mem_slave.wr_req) begin
            w_state_d = W_IDLE;
            wcnt_d    = 4'd0;
        end else if (wcnt == 4'(WR_WAIT)) begin
            wr_gnt    = 1'b1;
            w_state_d = W_IDLE;
            wcnt_d    = 4'd0;
        end else wcnt_d = wcnt + 4'd1;
        if (rst) wr_gnt = 1'b0;
    end

    assign mem_slave.rd_gnt = rd_gnt;
    assign mem_slave.wr_gnt = wr_gnt;

    // An error set in the same cycle as a clear takes priority
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= R_IDLE;
            w_state           <= W_IDLE;
            rcnt              <= 4'd0;
            wcnt              <= 4'd0;
            mem_slave.rd_data <= 32'd0;
            o_err             <= 1'b0;
            o_rd_cnt          <= 32'd0;
            o_wr_cnt          <= 32'd0;
        end else begin
            r_state <= r_state_d;
            w_state <= w_state_d;
            rcnt    <= rcnt_d;
            wcnt    <= wcnt_d;
            if (rd_gnt) begin
                mem_slave.rd_data <= rd_ok ? mem[rd_idx] : 32'd0;
                o_rd_cnt          <= o_rd_cnt + 32'd1;
            end
            if (wr_gnt) o_wr_cnt <= o_wr_cnt + 32'd1;
            if ((rd_gnt && !rd_ok) || (wr_gnt && !wr_ok)) o_err <= 1'b1;
            else if (i_err_clr) o_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_gnt && wr_ok)
            for (int b = 0; b < 4; b++)
                if (mem_slave.wr_be[b]) mem[wr_idx][8*b +: 8] <= mem_slave.wr_data[8*b +: 8];
    end
endmodule

// File: tb/tb_dualport_ram_slave.sv
// tb_dualport_ram_slave: randomized and directed checks of two RAM slaves (no wait / with wait states)
module tb_dualport_ram_slave;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst0, rst1, clr0, clr1, err0, err1;
    logic [31:0] rdc0, wrc0, rdc1, wrc1;
    int          checks = 0;
    int          failures = 0;

    dualport_bus b0();
    dualport_bus b1();

    dualport_ram_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_WAIT(0), .WR_WAIT(0)) dut0 (
        .clk(clk), .rst(rst0), .mem_slave(b0), .i_err_clr(clr0),
        .o_err(err0), .o_rd_cnt(rdc0), .o_wr_cnt(wrc0)
    );
    dualport_ram_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_WAIT(3), .WR_WAIT(1)) dut1 (
        .clk(clk), .rst(rst1), .mem_slave(b1), .i_err_clr(clr1),
        .o_err(err1), .o_rd_cnt(rdc1), .o_wr_cnt(wrc1)
    );

    always #5 clk = ~clk;

    logic [31:0] m0 [DEPTH];
    logic [31:0] e_rd0, e_rc0, e_wc0;
    logic        e_err0;
    logic        g_rd, g_wr;
    logic [7:0]  pr, pw;
    logic [31:0] d1a, d1b;

    function automatic logic in_rng(input logic [31:0] a);
        return (a - BASE) < 32'(DEPTH * 4);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2) % DEPTH;
    endfunction

    task automatic cyc0(input logic rr, input logic [31:0] ra, input logic ww, input logic [3:0] be,
                        input logic [31:0] wa, input logic [31:0] wd, input logic clr);
        b0.rd_req = rr; b0.rd_addr = ra; b0.rd_be = 4'hF;
        b0.wr_req = ww; b0.wr_be = be; b0.wr_addr = wa; b0.wr_data = wd; clr0 = clr;
        @(negedge clk);
        g_rd = b0.rd_gnt; g_wr = b0.wr_gnt;
        @(posedge clk); #1;
        b0.rd_req = 1'b0; b0.wr_req = 1'b0; clr0 = 1'b0;
        if (rr) e_rd0 = in_rng(ra) ? m0[widx(ra)] : 32'd0;
        if (ww && in_rng(wa))
            for (int b = 0; b < 4; b++) if (be[b]) m0[widx(wa)][8*b +: 8] = wd[8*b +: 8];
        if ((rr && !in_rng(ra)) || (ww && !in_rng(wa))) e_err0 = 1'b1;
        else if (clr) e_err0 = 1'b0;
        e_rc0 = e_rc0 + 32'(rr);
        e_wc0 = e_wc0 + 32'(ww);
    endtask

    task automatic cyc1(input logic rr, input logic [31:0] ra, input logic ww,
                        input logic [31:0] wa, input logic [31:0] wd, input logic r);
        b1.rd_req = rr; b1.rd_addr = ra; b1.rd_be = 4'hF;
        b1.wr_req = ww; b1.wr_be = 4'hF; b1.wr_addr = wa; b1.wr_data = wd; rst1 = r;
        @(negedge clk);
        g_rd = b1.rd_gnt; g_wr = b1.wr_gnt;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst0 = 1'b1; rst1 = 1'b1;
        b0.rd_req = 1'b1; b0.wr_req = 1'b1; b1.rd_req = 1'b1; b1.wr_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({b0.rd_gnt, b0.wr_gnt, b1.rd_gnt, b1.wr_gnt} !== 4'b0) begin
            failures++;
            $display("FAIL reset_gnt got %b exp 0000", {b0.rd_gnt, b0.wr_gnt, b1.rd_gnt, b1.wr_gnt});
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst0 = 1'b0; rst1 = 1'b0;
        b0.rd_req = 1'b0; b0.wr_req = 1'b0; b1.rd_req = 1'b0; b1.wr_req = 1'b0;
        e_rd0 = 32'd0; e_rc0 = 32'd0; e_wc0 = 32'd0; e_err0 = 1'b0;
        checks++;
        if ({b0.rd_data, err0, rdc0, wrc0} !== 97'd0) begin
            failures++;
            $display("FAIL reset_dut0 got rd=%h err=%b rc=%h wc=%h exp all 0", b0.rd_data, err0, rdc0, wrc0);
        end
        checks++;
        if ({b1.rd_data, err1, rdc1, wrc1} !== 97'd0) begin
            failures++;
            $display("FAIL reset_dut1 got rd=%h err=%b rc=%h wc=%h exp all 0", b1.rd_data, err1, rdc1, wrc1);
        end
    endtask

    task automatic fill0;
        for (int i = 0; i < DEPTH; i++) cyc0(1'b0, BASE, 1'b1, 4'hF, BASE + 32'(i * 4), $urandom, 1'b0);
    endtask

    task automatic test_wait0;
        cyc0(1'b0, BASE, 1'b1, 4'hF, BASE + 32'd8, 32'hDEAD_BEEF, 1'b0);
        checks++;
        if (g_wr !== 1'b1) begin failures++; $display("FAIL w0_wr_gnt got %b exp 1", g_wr); end
        cyc0(1'b1, BASE + 32'd8, 1'b0, 4'h0, BASE, 32'd0, 1'b0);
        checks++;
        if (g_rd !== 1'b1) begin failures++; $display("FAIL w0_rd_gnt got %b exp 1", g_rd); end
        checks++;
        if (b0.rd_data !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL w0_rd_data got %h exp deadbeef", b0.rd_data);
        end
        cyc0(1'b0, BASE, 1'b1, 4'b0100, BASE + 32'd8, 32'h00AA_0000, 1'b0);
        checks++;
        if (b0.rd_data !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL w0_rd_hold got %h exp deadbeef", b0.rd_data);
        end
        cyc0(1'b1, BASE + 32'd8, 1'b0, 4'h0, BASE, 32'd0, 1'b0);
        checks++;
        if (b0.rd_data !== 32'hDEAA_BEEF) begin
            failures++; $display("FAIL w0_byte_lane got %h exp deaabeef", b0.rd_data);
        end
    endtask

    task automatic test_same_cycle;
        cyc0(1'b0, BASE, 1'b1, 4'hF, BASE, 32'h1111_1111, 1'b0);
        cyc0(1'b1, BASE, 1'b1, 4'hF, BASE, 32'h2222_2222, 1'b0);
        checks++;
        if (b0.rd_data !== 32'h1111_1111) begin
            failures++; $display("FAIL rbw_old got %h exp 11111111", b0.rd_data);
        end
        cyc0(1'b1, BASE, 1'b0, 4'h0, BASE, 32'd0, 1'b0);
        checks++;
        if (b0.rd_data !== 32'h2222_2222) begin
            failures++; $display("FAIL rbw_new got %h exp 22222222", b0.rd_data);
        end
    endtask

    task automatic test_out_of_range;
        cyc0(1'b1, BASE + 32'(DEPTH * 4), 1'b0, 4'h0, BASE, 32'd0, 1'b0);
        checks++;
        if ({b0.rd_data, err0} !== {32'd0, 1'b1}) begin
            failures++; $display("FAIL oor_read got rd=%h err=%b exp rd=0 err=1", b0.rd_data, err0);
        end
        cyc0(1'b0, BASE, 1'b1, 4'hF, BASE + 32'(DEPTH * 4), $urandom, 1'b1);
        checks++;
        if (err0 !== 1'b1) begin failures++; $display("FAIL oor_set_wins got %b exp 1", err0); end
        for (int i = 0; i < DEPTH; i++) begin
            cyc0(1'b1, BASE + 32'(i * 4), 1'b0, 4'h0, BASE, 32'd0, 1'b0);
            checks++;
            if (b0.rd_data !== m0[i]) begin
                failures++; $display("FAIL oor_no_alias word %0d got %h exp %h", i, b0.rd_data, m0[i]);
            end
        end
        cyc0(1'b0, BASE, 1'b0, 4'h0, BASE, 32'd0, 1'b1);
        checks++;
        if (err0 !== 1'b0) begin failures++; $display("FAIL oor_clear got %b exp 0", err0); end
    endtask

    task automatic test_random;
        for (int n = 0; n < 300; n++) begin
            logic rr, ww, clr;
            logic [31:0] ra, wa, wd;
            logic [3:0] be;
            rr  = 1'($urandom);
            ww  = 1'($urandom);
            be  = 4'($urandom);
            wd  = $urandom;
            ra  = BASE + 32'($urandom_range(0, DEPTH + 1)) * 32'd4;
            wa  = BASE + 32'($urandom_range(0, DEPTH + 1)) * 32'd4;
            if ($urandom_range(0, 15) == 0) ra = BASE - 32'd4;
            clr = ($urandom_range(0, 5) == 0);
            cyc0(rr, ra, ww, be, wa, wd, clr);
            checks++;
            if ({g_rd, g_wr} !== {rr, ww}) begin
                failures++; $display("FAIL rnd_gnt n=%0d got %b exp %b", n, {g_rd, g_wr}, {rr, ww});
            end
            checks++;
            if (b0.rd_data !== e_rd0) begin
                failures++; $display("FAIL rnd_rd_data n=%0d got %h exp %h", n, b0.rd_data, e_rd0);
            end
            checks++;
            if ({err0, rdc0, wrc0} !== {e_err0, e_rc0, e_wc0}) begin
                failures++;
                $display("FAIL rnd_status n=%0d got err=%b rc=%h wc=%h exp err=%b rc=%h wc=%h",
                         n, err0, rdc0, wrc0, e_err0, e_rc0, e_wc0);
            end
        end
    endtask

    task automatic test_wrap;
        force dut0.o_rd_cnt = 32'hFFFF_FFFF;
        #1 release dut0.o_rd_cnt;
        e_rc0 = 32'hFFFF_FFFF;
        cyc0(1'b1, BASE, 1'b0, 4'h0, BASE, 32'd0, 1'b0);
        checks++;
        if (rdc0 !== 32'd0) begin failures++; $display("FAIL cnt_wrap got %h exp 00000000", rdc0); end
    endtask

    task automatic test_wait_states;
        d1a = $urandom;
        pr = 8'd0; pw = 8'd0;
        for (int c = 0; c < 4; c++) begin
            cyc1(1'b1, BASE + 32'd4, c < 2, BASE + 32'd4, d1a, 1'b0);
            pr = {pr[6:0], g_rd}; pw = {pw[6:0], g_wr};
        end
        checks++;
        if (pr[3:0] !== 4'b0001) begin failures++; $display("FAIL ws_rd_gnt got %b exp 0001", pr[3:0]); end
        checks++;
        if (pw[3:0] !== 4'b0100) begin failures++; $display("FAIL ws_wr_gnt got %b exp 0100", pw[3:0]); end
        checks++;
        if (b1.rd_data !== d1a) begin failures++; $display("FAIL ws_rd_data got %h exp %h", b1.rd_data, d1a); end
        checks++;
        if ({rdc1, wrc1} !== {32'd1, 32'd1}) begin
            failures++; $display("FAIL ws_cnt got rc=%h wc=%h exp 1 1", rdc1, wrc1);
        end
    endtask

    task automatic test_abort;
        pr = 8'd0;
        for (int c = 0; c < 7; c++) begin
            cyc1(c != 2, BASE + 32'd4, 1'b0, BASE, 32'd0, 1'b0);
            pr = {pr[6:0], g_rd};
        end
        checks++;
        if (pr[6:0] !== 7'b0000001) begin failures++; $display("FAIL abort_gnt got %b exp 0000001", pr[6:0]); end
        checks++;
        if (rdc1 !== 32'd2) begin failures++; $display("FAIL abort_cnt got %h exp 2", rdc1); end
    endtask

    task automatic test_back_to_back;
        d1b = $urandom;
        pr = 8'd0; pw = 8'd0;
        for (int c = 0; c < 8; c++) begin
            cyc1(1'b1, BASE + 32'd4, c < 4, BASE + 32'd12, d1b, 1'b0);
            pr = {pr[6:0], g_rd}; pw = {pw[6:0], g_wr};
        end
        checks++;
        if (pr !== 8'b0001_0001) begin failures++; $display("FAIL b2b_rd_gnt got %b exp 00010001", pr); end
        checks++;
        if (pw !== 8'b0101_0000) begin failures++; $display("FAIL b2b_wr_gnt got %b exp 01010000", pw); end
        checks++;
        if ({rdc1, wrc1} !== {32'd4, 32'd3}) begin
            failures++; $display("FAIL b2b_cnt got rc=%h wc=%h exp 4 3", rdc1, wrc1);
        end
    endtask

    task automatic test_reset_mid_wait;
        for (int c = 0; c < 4; c++) cyc1(1'b1, BASE + 32'(DEPTH * 4), 1'b0, BASE, 32'd0, 1'b0);
        checks++;
        if ({b1.rd_data, err1} !== {32'd0, 1'b1}) begin
            failures++; $display("FAIL rmw_oor got rd=%h err=%b exp rd=0 err=1", b1.rd_data, err1);
        end
        for (int c = 0; c < 4; c++) cyc1(1'b1, BASE + 32'd4, 1'b0, BASE, 32'd0, 1'b0);
        cyc1(1'b1, BASE + 32'd12, 1'b1, BASE + 32'd12, ~d1b, 1'b0);
        cyc1(1'b1, BASE + 32'd12, 1'b1, BASE + 32'd12, ~d1b, 1'b1);
        checks++;
        if ({g_rd, g_wr} !== 2'b00) begin failures++; $display("FAIL rmw_gnt got %b exp 00", {g_rd, g_wr}); end
        checks++;
        if ({b1.rd_data, err1, rdc1, wrc1} !== 97'd0) begin
            failures++;
            $display("FAIL rmw_state got rd=%h err=%b rc=%h wc=%h exp all 0", b1.rd_data, err1, rdc1, wrc1);
        end
        pr = 8'd0;
        for (int c = 0; c < 4; c++) begin
            cyc1(1'b1, BASE + 32'd12, 1'b0, BASE, 32'd0, 1'b0);
            pr = {pr[6:0], g_rd};
        end
        checks++;
        if (pr[3:0] !== 4'b0001) begin failures++; $display("FAIL rmw_restart got %b exp 0001", pr[3:0]); end
        checks++;
        if (b1.rd_data !== d1b) begin failures++; $display("FAIL rmw_no_write got %h exp %h", b1.rd_data, d1b); end
        for (int c = 0; c < 4; c++) cyc1(1'b1, BASE + 32'd4, 1'b0, BASE, 32'd0, 1'b0);
        checks++;
        if (b1.rd_data !== d1a) begin failures++; $display("FAIL rmw_survive got %h exp %h", b1.rd_data, d1a); end
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
        b0.rd_req = 1'b0; b0.rd_be = 4'hF; b0.rd_addr = BASE;
        b0.wr_req = 1'b0; b0.wr_be = 4'hF; b0.wr_addr = BASE; b0.wr_data = 32'd0;
        b1.rd_req = 1'b0; b1.rd_be = 4'hF; b1.rd_addr = BASE;
        b1.wr_req = 1'b0; b1.wr_be = 4'hF; b1.wr_addr = BASE; b1.wr_data = 32'd0;
        test_reset;
        fill0;
        test_wait0;
        test_same_cycle;
        test_out_of_range;
        test_random;
        test_wrap;
        test_wait_states;
        test_abort;
        test_back_to_back;
        test_reset_mid_wait;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dualport_ram_slave.md
# dualport_ram_slave

Word-addressed data RAM that acts as the slave end of the `dualport_bus` driven by the core's load/store stage. It accepts independent read and write requests, inserts a configurable number of wait states per access, and applies byte-enabled writes. It returns registered read data one cycle after grant, which is when the load/store stage samples it. Out-of-range accesses are flagged rather than aliased.

## Interface
- `DEPTH`, 4096: RAM size in 32-bit words; must be a power of two ≥ 4.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `DEPTH*4`.
- `RD_WAIT`, 0: wait cycles before `rd_gnt`, range 0..15.
- `WR_WAIT`, 0: wait cycles before `wr_gnt`, range 0..15.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `mem_slave`, interface, `dualport_bus.slave`:
  - inputs: `rd_req`, `rd_be[3:0]`, `rd_addr[31:0]`, `wr_req`, `wr_be[3:0]`, `wr_addr[31:0]`, `wr_data[31:0]`
  - outputs: `rd_gnt`, `rd_data[31:0]`, `wr_gnt`
- `i_err_clr`, input, 1: clears `o_err` (synchronous).
- `o_err`, output, 1: sticky flag for an out-of-range granted access.
- `o_rd_cnt`, output, 32: number of granted reads; wraps modulo 2^32.
- `o_wr_cnt`, output, 32: number of granted writes; wraps modulo 2^32.

## Operation
- Address decode:
  - word index = `(addr - BASE_ADDR) >> 2`, using `$clog2(DEPTH)` bits.
  - in-range ⇔ `addr - BASE_ADDR < DEPTH*4`.
  - `addr[1:0]` is ignored; the master always presents word-aligned addresses.
- Read port state machine, states `R_IDLE` and `R_WAIT`, with wait counter `rcnt` (4 bits):
  - `R_IDLE`: if `rd_req` and `RD_WAIT==0`, assert `rd_gnt` combinationally this cycle. If `rd_req` and `RD_WAIT>0`, go to `R_WAIT` with `rcnt=1`.
  - `R_WAIT`: if `rd_req` drops, abort and return to `R_IDLE` with `rcnt=0`. If `rcnt==RD_WAIT`, assert `rd_gnt` this cycle and go to `R_IDLE`. Otherwise `rcnt++`.
  - Changing `rd_addr` while in `R_WAIT` does not restart the count. The master must hold address and enables stable until grant.
- Write port: identical state machine (`W_IDLE`/`W_WAIT`, `wcnt`, `WR_WAIT`), fully independent of the read port.
- Grant actions, both committed at the edge closing the grant cycle:
  - Read grant: `rd_data <= mem[idx]` if in range, else 0. `rd_be` is not applied; the full word is returned and the master extracts lanes.
  - Write grant: for each lane `b` with `wr_be[b]`, `mem[idx][8b+7:8b] <= wr_data[8b+7:8b]`. Out-of-range writes are dropped. `wr_be==0` is granted as a no-op write.
- `rd_data` holds its last value until the next read grant; it never changes on write-only cycles.
- Same-cycle read and write grant to the same word: read-before-write. `rd_data` gets the old word and the memory gets the new bytes.
- `o_err`:
  - Set on any granted out-of-range read or write.
  - `i_err_clr` clears it.
  - If a new error and a clear occur in the same cycle, the set wins.
- Counters increment on the edge after each grant.

## Timing
- Reset values:
  - `rd_data`=0, `o_err`=0, `o_rd_cnt`=0, `o_wr_cnt`=0.
  - FSMs in `IDLE`, counters 0.
  - `rd_gnt`/`wr_gnt` are 0 during the reset cycle regardless of requests.
  - RAM contents are not cleared.
- Latency:
  - Grant occurs in request cycle + `*_WAIT`.
  - Read data is valid on `rd_data` in the cycle after `rd_gnt`.
  - Written data is readable by a read granted in the next cycle or later.
- Back-to-back:
  - With `WAIT=0`, one access per port per cycle.
  - With `WAIT=N>0`, each access occupies N+1 cycles. A request held high after grant starts a new count from `IDLE`.
- Reset asserted mid-wait aborts the access: no grant, no memory write. A request held through reset restarts its count from 0 after reset.
- No combinational path from `wr_*` to `rd_data`. `rd_gnt` depends combinationally only on `rd_req` and FSM state; `wr_gnt` likewise on `wr_req`.

## Test plan
- WAIT=0:
  - Write `32'hDEADBEEF`, be=`4'hF`, to `BASE+8`; next cycle read `BASE+8` → `rd_gnt` same cycle, `rd_data=32'hDEADBEEF` one cycle later.
  - Then write be=`4'b0100`, data `32'h00AA0000` → readback `32'hDEAABEEF`.
- RD_WAIT=3, WR_WAIT=1:
  - Read request held → `rd_gnt` high exactly in 4th request cycle.
  - Write gets `wr_gnt` in 2nd cycle.
  - Read request dropped after 2 cycles and reasserted → grant 3 cycles after reassertion.
- Same-cycle read+write to `BASE+0`, holding `32'h11111111`, writing `32'h22222222` → `rd_data=32'h11111111`; following read → `32'h22222222`.
- Read `BASE+DEPTH*4` → `rd_data=0`, `o_err=1`.
  - Write there leaves all RAM words unchanged.
  - `i_err_clr` alongside another out-of-range grant → `o_err` stays 1; clear alone → 0.
- Assert `rst` during `R_WAIT` → no grant; `rd_data`, `o_rd_cnt`, and `o_err` return to 0; previously written RAM contents survive.
- Preload `o_rd_cnt` near wrap via 2^32−1 forced value, then grant one read → `o_rd_cnt=0`.
